// File: rtl/sar_seq_pkg.sv
// ============================================================================
// Module   : sar_seq_pkg
// Purpose  : Shared types, constants and round-robin pick helper for the
//            SAR ADC scan sequencer (optional macro: SAR_SEQ_OVERSAMPLE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam int OVERSAMPLE_PASSES = 4;

  // Widest requester vector the helper accepts; callers zero-extend.
  localparam int RR_MAX_CH = 8;
  localparam int RR_IDX_W  = 3;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request at or above ptr, wrapping at num_ch.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                       input logic [RR_IDX_W-1:0]  ptr,
                                       input int                   num_ch);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = RR_MAX_CH - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= num_ch) k = k - num_ch;
      if ((i < num_ch) && req[k[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_seq_rr_arbiter.sv
// ============================================================================
// Module   : sar_seq_rr_arbiter
// Purpose  : Combinational round-robin pick with a registered rotating pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_seq_rr_arbiter
  import sar_seq_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         i_req,
  input  logic                      i_adv,
  input  logic [$clog2(NUM_CH)-1:0] i_last,
  output logic                      o_found,
  output logic [$clog2(NUM_CH)-1:0] o_grant
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]     r_ptr;
  logic [RR_MAX_CH-1:0] w_req_ext;
  rr_pick_t             w_pick;
  logic                 w_unused_idx;

  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NUM_CH-1:0] = i_req;
  end

  assign w_pick       = rr_pick(w_req_ext, RR_IDX_W'(r_ptr), NUM_CH);
  assign o_found      = w_pick.found;
  assign o_grant      = w_pick.idx[IDX_W-1:0];
  assign w_unused_idx = ^w_pick.idx;

  // Pointer moves just past the channel that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_last == IDX_W'(NUM_CH - 1)) ? '0 : i_last + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sar_adc_scan_sequencer.sv
// ============================================================================
// Module   : sar_adc_scan_sequencer
// Purpose  : Round-robin scan sequencer sharing one SAR ADC between NUM_CH
//            requesters. Optional 4x oversampling: SAR_SEQ_OVERSAMPLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_scan_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int NUM_BITS       = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [2*NUM_CH-1:0]       i_cfg_rate,
  output logic [NUM_CH-1:0]         o_ack,
  output logic [NUM_BITS-1:0]       o_result,
  output logic                      o_result_err,
  output logic                      o_busy,
  output logic [$clog2(NUM_CH)-1:0] o_ch_sel,
  output logic                      o_adc_rst_n,
  output logic [1:0]                o_adc_sample_rate,
  input  logic [NUM_BITS-1:0]       i_adc_d_out,
  input  logic                      i_adc_eoc
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  seq_state_e          r_state;
  logic [3:0]          r_settle_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_eoc_prev;
  logic [NUM_CH-1:0]   r_ack;
  logic [NUM_BITS-1:0] r_result;
  logic                r_err;
  logic                r_busy;
  logic [IDX_W-1:0]    r_ch_sel;
  logic                r_adc_rst_n;
  logic [1:0]          r_rate;

  logic                w_found;
  logic [IDX_W-1:0]    w_grant;
  logic [1:0]          w_grant_rate;
  logic [NUM_CH-1:0]   w_ack_onehot;
  logic                w_eoc_rise;

`ifdef SAR_SEQ_OVERSAMPLE_EN
  logic [NUM_BITS+1:0] r_acc;
  logic [1:0]          r_pass;
  logic [NUM_BITS+1:0] w_acc_sum;

  assign w_acc_sum = r_acc + (NUM_BITS + 2)'(i_adc_d_out);
`endif

  sar_seq_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_adv   (r_state == DONE),
    .i_last  (r_ch_sel),
    .o_found (w_found),
    .o_grant (w_grant)
  );

  always_comb begin
    w_grant_rate = '0;
    w_ack_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == IDX_W'(i)) w_grant_rate = i_cfg_rate[2*i +: 2];
      w_ack_onehot[i] = (r_ch_sel == IDX_W'(i));
    end
  end

  // The previous-sample register tracks EOC every cycle, so a level that is
  // already high when CONVERT starts never looks like a fresh edge.
  assign w_eoc_rise = i_adc_eoc & ~r_eoc_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_eoc_prev   <= 1'b0;
      r_ack        <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_ch_sel     <= '0;
      r_adc_rst_n  <= 1'b0;
      r_rate       <= '0;
`ifdef SAR_SEQ_OVERSAMPLE_EN
      r_acc        <= '0;
      r_pass       <= '0;
`endif
    end else begin
      r_eoc_prev <= i_adc_eoc;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= SETTLE;
            r_ch_sel     <= w_grant;
            r_rate       <= w_grant_rate;
            r_busy       <= 1'b1;
            r_settle_cnt <= '0;
`ifdef SAR_SEQ_OVERSAMPLE_EN
            r_acc        <= '0;
            r_pass       <= '0;
`endif
          end
        end
        SETTLE: begin
          if (r_settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
            r_state     <= CONVERT;
            r_adc_rst_n <= 1'b1;
            r_tmo_cnt   <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        CONVERT: begin
          // An EOC edge wins over a simultaneous timeout.
          if (w_eoc_rise) begin
`ifdef SAR_SEQ_OVERSAMPLE_EN
            if (r_pass == 2'(OVERSAMPLE_PASSES - 1)) begin
              r_result    <= w_acc_sum[NUM_BITS+1:2];
              r_ack       <= w_ack_onehot;
              r_adc_rst_n <= 1'b0;
              r_state     <= DONE;
            end else begin
              r_acc        <= w_acc_sum;
              r_pass       <= r_pass + 1'b1;
              r_adc_rst_n  <= 1'b0;
              r_settle_cnt <= '0;
              r_state      <= SETTLE;
            end
`else
            r_result    <= i_adc_d_out;
            r_ack       <= w_ack_onehot;
            r_adc_rst_n <= 1'b0;
            r_state     <= DONE;
`endif
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_ack       <= w_ack_onehot;
            r_adc_rst_n <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack             = r_ack;
  assign o_result          = r_result;
  assign o_result_err      = r_err;
  assign o_busy            = r_busy;
  assign o_ch_sel          = r_ch_sel;
  assign o_adc_rst_n       = r_adc_rst_n;
  assign o_adc_sample_rate = r_rate;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_scan_sequencer.sv
// ============================================================================
// Module   : tb_sar_adc_scan_sequencer
// Purpose  : Self-checking bench with a behavioural SAR ADC and a scoreboard.
//            Extra oversampling sequence when SAR_SEQ_OVERSAMPLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_adc_scan_sequencer;

  localparam int SETTLE = 2;
  localparam int TMO    = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] cfg_rate;
  logic [3:0] ack;
  logic [3:0] result;
  logic       result_err;
  logic       busy;
  logic [1:0] ch_sel;
  logic       adc_rst_n;
  logic [1:0] adc_sample_rate;
  logic [3:0] adc_d_out = 4'hF;
  logic       adc_eoc   = 1'b0;

  sar_adc_scan_sequencer #(
    .NUM_CH(4), .NUM_BITS(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req             (req),
    .i_cfg_rate        (cfg_rate),
    .o_ack             (ack),
    .o_result          (result),
    .o_result_err      (result_err),
    .o_busy            (busy),
    .o_ch_sel          (ch_sel),
    .o_adc_rst_n       (adc_rst_n),
    .o_adc_sample_rate (adc_sample_rate),
    .i_adc_d_out       (adc_d_out),
    .i_adc_eoc         (adc_eoc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Behavioural ADC: EOC rises m_lat cycles after release, never if m_never.
  logic       m_never = 1'b0;
  logic       m_stale = 1'b0;
  int         m_lat   = 3;
  logic [3:0] m_code  = 4'h0;
  int         m_cnt   = 0;

  always @(posedge clk) begin
    if (!adc_rst_n) begin
      m_cnt     <= 0;
      adc_eoc   <= m_stale;
      adc_d_out <= 4'hF;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!m_never && m_cnt >= m_lat) begin
        adc_eoc   <= 1'b1;
        adc_d_out <= m_code;
      end else begin
        adc_eoc   <= 1'b0;
        adc_d_out <= 4'hF;
      end
    end
  end

  typedef struct {
    logic [3:0] ack;
    logic [3:0] result;
    logic       err;
    int         ch;
    int         rate;
    int         conv;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;

  function automatic int rate_of(input logic [7:0] cfg, input int ch);
    logic [7:0] s;
    s = cfg >> (2 * ch);
    return int'(s[1:0]);
  endfunction

  task automatic push_exp(input int ch, input int rate, input logic [3:0] res,
                          input logic err, input int conv);
    exp_t e;
    e.ack    = 4'b0001 << ch;
    e.result = res;
    e.err    = err;
    e.ch     = ch;
    e.rate   = rate;
    e.conv   = conv;
    sb.push_back(e);
  endtask

  // Monitor: grant-time checks on adc_rst_n rising, result checks on ack.
  logic prev_rst = 1'b0;
  int   lowcnt = 0;
  int   hicnt = 0;
  logic contention_on = 1'b0;
  int   idle_run = 0;
  int   max_idle = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rst = 1'b0;
      lowcnt   = 0;
      hicnt    = 0;
    end else begin
      if (ack != 4'b0000) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", int'(ack), 0);
        end else begin
          e_cur = sb.pop_front();
          check("ack", int'(ack), int'(e_cur.ack));
          check("result", int'(result), int'(e_cur.result));
          check("result_err", int'(result_err), int'(e_cur.err));
          check("convert_len", hicnt, e_cur.conv);
          check("adc_rst_n_in_done", int'(adc_rst_n), 0);
        end
      end else if (result_err) begin
        check("err_without_ack", 1, 0);
      end
      if (adc_rst_n && !prev_rst) begin
        if (sb.size() == 0) begin
          check("release_unexpected", 1, 0);
        end else begin
          check("ch_sel", int'(ch_sel), sb[0].ch);
          check("sample_rate", int'(adc_sample_rate), sb[0].rate);
          check("settle_len", lowcnt, SETTLE);
        end
        lowcnt = 0;
        hicnt  = 0;
      end
      if (adc_rst_n) hicnt++;
      else if (busy && ack == 4'b0000) lowcnt++;
      if (!busy) lowcnt = 0;
      prev_rst = adc_rst_n;
      if (contention_on) begin
        if (!busy) idle_run++;
        else idle_run = 0;
        if (idle_run > max_idle) max_idle = idle_run;
      end
    end
  end

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0000 && n < budget);
    if (ack == 4'b0000) check("ack_wait_expired", 0, 1);
  endtask

  task automatic wait_rst_level(input logic lvl, input int budget);
    int n;
    n = 0;
    while (adc_rst_n != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (adc_rst_n != lvl) check("adc_rst_n_wait_expired", int'(adc_rst_n), int'(lvl));
  endtask

  task automatic run_one(input logic [3:0] r, input logic [7:0] cfg, input logic [3:0] code,
                         input int lat, input int ch, input logic err);
    m_code = code;
    m_lat  = lat;
    push_exp(ch, rate_of(cfg, ch), err ? 4'h0 : code, err, err ? TMO : lat + 2);
    req      = r;
    cfg_rate = cfg;
    @(negedge clk);
    cfg_rate = ~cfg;
    wait_ack(4 * (TMO + 20));
    req = 4'b0000;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [7:0] cfg;
    logic [3:0] code;
    int         lat;
    int         ch;
  } vec_t;

  vec_t       vecs[7];
  logic [3:0] ccode[8];
  int         clat[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{req: 4'b0100, cfg: 8'b00_10_00_00, code: 4'hB, lat: 3, ch: 2};
    vecs[1] = '{req: 4'b0011, cfg: 8'b00_00_11_01, code: 4'h5, lat: 1, ch: 0};
    vecs[2] = '{req: 4'b0101, cfg: 8'b11_10_01_00, code: 4'h0, lat: 6, ch: 2};
    vecs[3] = '{req: 4'b1010, cfg: 8'b01_11_10_00, code: 4'hF, lat: 2, ch: 3};
    vecs[4] = '{req: 4'b1000, cfg: 8'b10_00_00_11, code: 4'h7, lat: 4, ch: 3};
    vecs[5] = '{req: 4'b0010, cfg: 8'b00_00_11_00, code: 4'hA, lat: 3, ch: 1};
    vecs[6] = '{req: 4'b1000, cfg: 8'b11_00_00_00, code: 4'h1, lat: 2, ch: 3};
    ccode = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD, 4'hE, 4'h9};
    clat  = '{2, 3, 4, 1, 5, 2, 3, 2};

    rst_n    = 1'b0;
    req      = 4'b0000;
    cfg_rate = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_result", int'(result), 0);
    check("rst_result_err", int'(result_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ch_sel", int'(ch_sel), 0);
    check("rst_adc_rst_n", int'(adc_rst_n), 0);
    check("rst_sample_rate", int'(adc_sample_rate), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_one(vecs[i].req, vecs[i].cfg, vecs[i].code, vecs[i].lat, vecs[i].ch, 1'b0);

    // All channels requesting: grants rotate from channel 0.
    m_code = ccode[0];
    m_lat  = clat[0];
    for (int k = 0; k < 8; k++) push_exp(k % 4, k % 4, ccode[k], 1'b0, clat[k] + 2);
    cfg_rate      = 8'b11_10_01_00;
    req           = 4'b1111;
    idle_run      = 0;
    max_idle      = 0;
    contention_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_ack(4 * (TMO + 20));
      if (k < 7) begin
        m_code = ccode[k + 1];
        m_lat  = clat[k + 1];
      end
    end
    req           = 4'b0000;
    contention_on = 1'b0;
    check("busy_max_gap", max_idle, 1);
    @(negedge clk);

    m_never = 1'b1;
    run_one(4'b0010, 8'b00_00_01_00, 4'h7, 3, 1, 1'b1);
    m_never = 1'b0;

    m_stale = 1'b1;
    run_one(4'b0001, 8'b00_00_00_11, 4'h9, 5, 0, 1'b0);
    m_stale = 1'b0;
    @(negedge clk);

    // Reset in the middle of CONVERT, then a fresh grant from pointer 0.
    m_lat = 20;
    push_exp(2, 1, 4'h6, 1'b0, 22);
    cfg_rate = 8'b00_01_00_00;
    req      = 4'b0100;
    wait_rst_level(1'b1, 20);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_adc_rst_n", int'(adc_rst_n), 0);
    check("midrst_ack", int'(ack), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ch_sel", int'(ch_sel), 0);
    check("midrst_sample_rate", int'(adc_sample_rate), 0);
    repeat (2) @(negedge clk);
    sb.delete();
    m_lat    = 2;
    m_code   = 4'hC;
    req      = 4'b1001;
    cfg_rate = 8'b10_00_00_01;
    push_exp(0, 1, 4'hC, 1'b0, 4);
    rst_n = 1'b1;
    wait_ack(4 * (TMO + 20));
    req = 4'b0000;
    @(negedge clk);

`ifdef SAR_SEQ_OVERSAMPLE_EN
    m_lat    = 3;
    m_code   = 4'h3;
    cfg_rate = 8'b00_00_10_00;
    push_exp(1, 2, 4'h4, 1'b0, 5);
    req = 4'b0010;
    for (int p = 0; p < 4; p++) begin
      wait_rst_level(1'b1, 20);
      m_code = 4'(3 + p);
      if (p < 3) wait_rst_level(1'b0, 20);
    end
    wait_ack(4 * (TMO + 20));
    req = 4'b0000;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
